// File: rtl/ddr_cmd_encoder.sv
// DDR4 command-pin encoder: init-phase flag commands, post-init host commands,
// and self-scheduled periodic refresh (PREA, tRP, REF, tRFC) with host back-pressure.
module ddr_cmd_encoder #(
    parameter int unsigned T_REFI = 7800,
    parameter int unsigned T_RP   = 16,
    parameter int unsigned T_RFC  = 280
) (
    input  logic        CK_t,
    input  logic        reset,
    input  logic        ini_done,
    input  logic        des_rdy,
    input  logic        mrs_rdy,
    input  logic        zqcl_rdy,
    input  logic [17:0] mode_reg,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_cmd,
    input  logic [1:0]  req_bg,
    input  logic [1:0]  req_ba,
    input  logic [17:0] req_row,
    input  logic [9:0]  req_col,
    output logic        CS_n,
    output logic        ACT_n,
    output logic        RAS_n,
    output logic        CAS_n,
    output logic        WE_n,
    output logic [1:0]  BG,
    output logic [1:0]  BA,
    output logic [17:0] A,
    output logic        ref_busy,
    output logic        ref_overrun
);

    localparam int unsigned W_REFI = $clog2(T_REFI) + 1;
    localparam int unsigned W_RP   = $clog2(T_RP) + 1;
    localparam int unsigned W_RFC  = $clog2(T_RFC) + 1;

    // {CS_n, ACT_n, RAS_n, CAS_n, WE_n}
    localparam logic [4:0] PIN_DES  = 5'b11111;
    localparam logic [4:0] PIN_MRS  = 5'b01000;
    localparam logic [4:0] PIN_REF  = 5'b01001;
    localparam logic [4:0] PIN_PRE  = 5'b01010;
    localparam logic [4:0] PIN_ZQCL = 5'b01110;
    localparam logic [4:0] PIN_WR   = 5'b01100;
    localparam logic [4:0] PIN_RD   = 5'b01101;

    localparam logic [2:0] CMD_ACT  = 3'd0;
    localparam logic [2:0] CMD_RD   = 3'd1;
    localparam logic [2:0] CMD_WR   = 3'd2;
    localparam logic [2:0] CMD_PRE  = 3'd3;
    localparam logic [2:0] CMD_PREA = 3'd4;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REF_PREA,
        S_REF_WAIT_RP,
        S_REF_ISSUE,
        S_REF_WAIT_RFC
    } state_e;

    state_e              state_q, state_d;
    logic [4:0]          pins_q, pins_d;
    logic [1:0]          bg_q, bg_d;
    logic [1:0]          ba_q, ba_d;
    logic [17:0]         a_q, a_d;
    logic                req_ready_q, req_ready_d;
    logic                ref_busy_q, ref_busy_d;
    logic                ref_overrun_q, ref_overrun_d;
    logic                ref_pending_q, ref_pending_d;
    logic [W_REFI-1:0]   refi_cnt_q, refi_cnt_d;
    logic [W_RP-1:0]     rp_cnt_q, rp_cnt_d;
    logic [W_RFC-1:0]    rfc_cnt_q, rfc_cnt_d;
    logic                refi_expire;

    // des_rdy needs no decode (idle pins are DES anyway); mode_reg[17] is reserved
    logic unused_inputs;
    assign unused_inputs = ^{des_rdy, mode_reg[17]};

    always_comb begin
        state_d       = state_q;
        pins_d        = PIN_DES;
        bg_d          = 2'b00;
        ba_d          = 2'b00;
        a_d           = 18'h0;
        ref_pending_d = ref_pending_q;
        ref_overrun_d = ref_overrun_q;
        refi_cnt_d    = refi_cnt_q;
        rp_cnt_d      = rp_cnt_q;
        rfc_cnt_d     = rfc_cnt_q;
        refi_expire   = 1'b0;

        // refresh interval timer runs whenever init is complete
        if (state_q != S_INIT) begin
            if (refi_cnt_q == '0) begin
                refi_expire   = 1'b1;
                refi_cnt_d    = W_REFI'(T_REFI - 1);
                ref_pending_d = 1'b1;
                if (ref_pending_q || (state_q != S_IDLE)) begin
                    ref_overrun_d = 1'b1;
                end
            end else begin
                refi_cnt_d = refi_cnt_q - W_REFI'(1);
            end
        end

        case (state_q)
            S_INIT: begin
                if (mrs_rdy) begin
                    pins_d = PIN_MRS;
                    bg_d   = {1'b0, mode_reg[16]};
                    ba_d   = mode_reg[15:14];
                    a_d    = {4'b0000, mode_reg[13:0]};
                end else if (zqcl_rdy) begin
                    pins_d    = PIN_ZQCL;
                    a_d[10]   = 1'b1;
                end
                if (ini_done) begin
                    state_d    = S_IDLE;
                    refi_cnt_d = W_REFI'(T_REFI - 1);
                end
            end
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    case (req_cmd)
                        CMD_ACT: begin
                            pins_d = {2'b00, req_row[16:14]};
                            bg_d   = req_bg;
                            ba_d   = req_ba;
                            a_d    = {req_row[17], 3'b000, req_row[13:0]};
                        end
                        CMD_RD, CMD_WR: begin
                            pins_d = (req_cmd == CMD_RD) ? PIN_RD : PIN_WR;
                            bg_d   = req_bg;
                            ba_d   = req_ba;
                            a_d    = {5'b00000, 1'b1, 2'b00, req_col};
                        end
                        CMD_PRE: begin
                            pins_d = PIN_PRE;
                            bg_d   = req_bg;
                            ba_d   = req_ba;
                        end
                        CMD_PREA: begin
                            pins_d  = PIN_PRE;
                            a_d[10] = 1'b1;
                        end
                        default: pins_d = PIN_DES;
                    endcase
                end
                // an accepted request goes out first; refresh starts next cycle
                if (ref_pending_d) begin
                    state_d = S_REF_PREA;
                end
            end
            S_REF_PREA: begin
                pins_d   = PIN_PRE;
                a_d[10]  = 1'b1;
                rp_cnt_d = W_RP'(T_RP - 2);
                state_d  = S_REF_WAIT_RP;
            end
            S_REF_WAIT_RP: begin
                if (rp_cnt_q == '0) begin
                    state_d = S_REF_ISSUE;
                end else begin
                    rp_cnt_d = rp_cnt_q - W_RP'(1);
                end
            end
            S_REF_ISSUE: begin
                pins_d        = PIN_REF;
                ref_pending_d = refi_expire;
                rfc_cnt_d     = W_RFC'(T_RFC - 1);
                state_d       = S_REF_WAIT_RFC;
            end
            S_REF_WAIT_RFC: begin
                if (rfc_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    rfc_cnt_d = rfc_cnt_q - W_RFC'(1);
                end
            end
            default: state_d = S_INIT;
        endcase

        // losing ini_done aborts everything, including a refresh in flight
        if ((state_q != S_INIT) && !ini_done) begin
            state_d       = S_INIT;
            pins_d        = PIN_DES;
            bg_d          = 2'b00;
            ba_d          = 2'b00;
            a_d           = 18'h0;
            ref_pending_d = 1'b0;
        end

        req_ready_d = (state_d == S_IDLE) && !ref_pending_d;
        ref_busy_d  = state_d inside {S_REF_WAIT_RP, S_REF_ISSUE, S_REF_WAIT_RFC};
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            state_q       <= S_INIT;
            pins_q        <= PIN_DES;
            bg_q          <= 2'b00;
            ba_q          <= 2'b00;
            a_q           <= 18'h0;
            req_ready_q   <= 1'b0;
            ref_busy_q    <= 1'b0;
            ref_overrun_q <= 1'b0;
            ref_pending_q <= 1'b0;
            refi_cnt_q    <= W_REFI'(T_REFI - 1);
            rp_cnt_q      <= '0;
            rfc_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            pins_q        <= pins_d;
            bg_q          <= bg_d;
            ba_q          <= ba_d;
            a_q           <= a_d;
            req_ready_q   <= req_ready_d;
            ref_busy_q    <= ref_busy_d;
            ref_overrun_q <= ref_overrun_d;
            ref_pending_q <= ref_pending_d;
            refi_cnt_q    <= refi_cnt_d;
            rp_cnt_q      <= rp_cnt_d;
            rfc_cnt_q     <= rfc_cnt_d;
        end
    end

    assign {CS_n, ACT_n, RAS_n, CAS_n, WE_n} = pins_q;
    assign BG          = bg_q;
    assign BA          = ba_q;
    assign A           = a_q;
    assign req_ready   = req_ready_q;
    assign ref_busy    = ref_busy_q;
    assign ref_overrun = ref_overrun_q;

endmodule

// File: tb/tb_ddr_cmd_encoder.sv
// Bench for ddr_cmd_encoder: init-flag vector table, randomized host traffic against a
// refresh-schedule reference model, and abort/reset/overrun sequences.
module tb_ddr_cmd_encoder;

    localparam int TA_REFI = 20;
    localparam int TA_RP   = 4;
    localparam int TA_RFC  = 10;
    localparam int TB_REFI = 8;

    localparam logic [26:0] BUS_DES  = {5'b11111, 22'h0};
    localparam logic [26:0] BUS_PREA = {5'b01010, 4'b0000, 18'h00400};
    localparam logic [26:0] BUS_REF  = {5'b01001, 22'h0};

    logic        CK_t = 1'b0;
    logic        reset, ini_done, des_rdy, mrs_rdy, zqcl_rdy, req_valid;
    logic [17:0] mode_reg, req_row;
    logic [2:0]  req_cmd;
    logic [1:0]  req_bg, req_ba;
    logic [9:0]  req_col;

    logic        a_cs_n, a_act_n, a_ras_n, a_cas_n, a_we_n, a_rdy, a_busy, a_ovr;
    logic [1:0]  a_bg, a_ba;
    logic [17:0] a_addr;
    logic        b_cs_n, b_act_n, b_ras_n, b_cas_n, b_we_n, b_rdy, b_busy, b_ovr;
    logic [1:0]  b_bg, b_ba;
    logic [17:0] b_addr;
    logic [26:0] a_bus;

    int errors = 0;
    int checks = 0;

    always #5 CK_t = ~CK_t;

    assign a_bus = {a_cs_n, a_act_n, a_ras_n, a_cas_n, a_we_n, a_bg, a_ba, a_addr};

    ddr_cmd_encoder #(.T_REFI(TA_REFI), .T_RP(TA_RP), .T_RFC(TA_RFC)) dut_a (
        .CK_t(CK_t), .reset(reset), .ini_done(ini_done), .des_rdy(des_rdy),
        .mrs_rdy(mrs_rdy), .zqcl_rdy(zqcl_rdy), .mode_reg(mode_reg),
        .req_valid(req_valid), .req_ready(a_rdy), .req_cmd(req_cmd),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .CS_n(a_cs_n), .ACT_n(a_act_n), .RAS_n(a_ras_n), .CAS_n(a_cas_n), .WE_n(a_we_n),
        .BG(a_bg), .BA(a_ba), .A(a_addr), .ref_busy(a_busy), .ref_overrun(a_ovr)
    );

    // short-interval instance so a second expiry lands inside tRFC
    ddr_cmd_encoder #(.T_REFI(TB_REFI), .T_RP(TA_RP), .T_RFC(TA_RFC)) dut_b (
        .CK_t(CK_t), .reset(reset), .ini_done(ini_done), .des_rdy(des_rdy),
        .mrs_rdy(mrs_rdy), .zqcl_rdy(zqcl_rdy), .mode_reg(mode_reg),
        .req_valid(req_valid), .req_ready(b_rdy), .req_cmd(req_cmd),
        .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .CS_n(b_cs_n), .ACT_n(b_act_n), .RAS_n(b_ras_n), .CAS_n(b_cas_n), .WE_n(b_we_n),
        .BG(b_bg), .BA(b_ba), .A(b_addr), .ref_busy(b_busy), .ref_overrun(b_ovr)
    );

    typedef struct packed {
        logic        mrs;
        logic        zq;
        logic        des;
        logic [17:0] mode;
        logic [26:0] exp_bus;
    } ivec_t;

    ivec_t vecs [6];

    task automatic tick();
        @(posedge CK_t);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Host command -> {pins, BG, BA, A} from the command table
    function automatic logic [26:0] enc_req(input logic [2:0] cmd, input logic [1:0] bg,
                                            input logic [1:0] ba, input logic [17:0] row,
                                            input logic [9:0] col);
        logic [26:0] r;
        case (cmd)
            3'd0:    r = {2'b00, 3'(row >> 14), bg, ba, row & 18'h23FFF};
            3'd1:    r = {5'b01101, bg, ba, 18'h01000 | 18'(col)};
            3'd2:    r = {5'b01100, bg, ba, 18'h01000 | 18'(col)};
            3'd3:    r = {5'b01010, bg, ba, 18'h0};
            3'd4:    r = BUS_PREA;
            default: r = BUS_DES;
        endcase
        return r;
    endfunction

    // Refresh schedule for instance A, m = edges since IDLE entry.
    // Expiry edge e = k*T_REFI (k>=1); PREA at e+1, REF at e+1+T_RP, host back at e+1+T_RP+T_RFC.
    function automatic bit rdy_exp(input int m);
        if (m < TA_REFI) return 1'b1;
        return (m % TA_REFI) >= (1 + TA_RP + TA_RFC);
    endfunction

    function automatic bit busy_exp(input int m);
        if (m < TA_REFI) return 1'b0;
        return ((m % TA_REFI) >= 1) && ((m % TA_REFI) < (1 + TA_RP + TA_RFC));
    endfunction

    function automatic logic [26:0] ref_bus_exp(input int m);
        if (m >= TA_REFI && (m % TA_REFI) == 1) return BUS_PREA;
        if (m >= TA_REFI && (m % TA_REFI) == 1 + TA_RP) return BUS_REF;
        return BUS_DES;
    endfunction

    initial begin
        logic [26:0] exp_bus;
        bit          xfer;

        vecs[0] = '{1'b1, 1'b0, 1'b0, {1'b0, 3'b011, 14'h0000}, {5'b01000, 2'd0, 2'd3, 18'h0}};
        vecs[1] = '{1'b1, 1'b1, 1'b0, {1'b1, 3'b101, 14'h2A5C}, {5'b01000, 2'd1, 2'd1, 18'h02A5C}};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 18'h3FFFF, {5'b01110, 4'b0000, 18'h00400}};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 18'h12345, BUS_DES};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 18'h0, BUS_DES};
        vecs[5] = '{1'b1, 1'b0, 1'b1, {1'b0, 3'b110, 14'h3FFF}, {5'b01000, 2'd1, 2'd2, 18'h03FFF}};

        reset = 1'b1; ini_done = 1'b0; des_rdy = 1'b0; mrs_rdy = 1'b0; zqcl_rdy = 1'b0;
        mode_reg = '0; req_valid = 1'b0; req_cmd = '0; req_bg = '0; req_ba = '0;
        req_row = '0; req_col = '0;
        repeat (2) tick();
        chk("reset_bus", 32'(a_bus), 32'(BUS_DES));
        chk("reset_ready", 32'(a_rdy), 32'd0);
        chk("reset_busy", 32'(a_busy), 32'd0);
        chk("reset_overrun", 32'(a_ovr), 32'd0);
        reset = 1'b0;
        tick();
        chk("init_idle_bus", 32'(a_bus), 32'(BUS_DES));

        // init-phase flag vectors, each followed by a DES cycle
        for (int i = 0; i < 6; i++) begin
            mrs_rdy = vecs[i].mrs; zqcl_rdy = vecs[i].zq; des_rdy = vecs[i].des;
            mode_reg = vecs[i].mode;
            tick();
            chk($sformatf("init_vec%0d_bus", i), 32'(a_bus), 32'(vecs[i].exp_bus));
            chk($sformatf("init_vec%0d_ready", i), 32'(a_rdy), 32'd0);
            mrs_rdy = 1'b0; zqcl_rdy = 1'b0; des_rdy = 1'b0;
            tick();
            chk($sformatf("init_vec%0d_des_after", i), 32'(a_bus), 32'(BUS_DES));
        end

        // enter IDLE; host fully valid for two refresh periods, then random
        ini_done = 1'b1;
        tick();
        chk("idle_entry_ready", 32'(a_rdy), 32'd1);
        for (int m = 1; m <= 130; m++) begin
            if (m == 1) begin
                req_valid = 1'b1; req_cmd = 3'd0; req_bg = 2'd1; req_ba = 2'd2;
                req_row = 18'h1C005; req_col = 10'h0;
            end else if (m == 2) begin
                req_valid = 1'b1; req_cmd = 3'd1; req_bg = 2'd1; req_ba = 2'd2;
                req_row = 18'h0; req_col = 10'h3F8;
            end else begin
                req_valid = (m <= 2 * TA_REFI) ? 1'b1 : ($urandom_range(0, 3) != 0);
                req_cmd = 3'($urandom_range(0, 7));
                req_bg = 2'($urandom); req_ba = 2'($urandom);
                req_row = 18'($urandom); req_col = 10'($urandom);
            end
            xfer = req_valid && rdy_exp(m - 1);
            exp_bus = xfer ? enc_req(req_cmd, req_bg, req_ba, req_row, req_col) : ref_bus_exp(m);
            tick();
            chk($sformatf("idle_bus_m%0d", m), 32'(a_bus), 32'(exp_bus));
            chk($sformatf("idle_ready_m%0d", m), 32'(a_rdy), 32'(rdy_exp(m)));
            chk($sformatf("idle_busy_m%0d", m), 32'(a_busy), 32'(busy_exp(m)));
            chk($sformatf("idle_overrun_m%0d", m), 32'(a_ovr), 32'd0);
        end

        // drop ini_done in the middle of tRFC
        ini_done = 1'b0; req_valid = 1'b1; req_cmd = 3'd1;
        tick();
        chk("drop_bus", 32'(a_bus), 32'(BUS_DES));
        chk("drop_ready", 32'(a_rdy), 32'd0);
        chk("drop_busy", 32'(a_busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("drop_hold_bus%0d", k), 32'(a_bus), 32'(BUS_DES));
        end

        // reset pulse during REF_WAIT_RP: no REF may follow
        req_valid = 1'b0; ini_done = 1'b1;
        tick();
        for (int m = 1; m <= 1 + TA_REFI + 1; m++) begin
            tick();
            if (m == TA_REFI + 1) chk("rst_seq_prea", 32'(a_bus), 32'(BUS_PREA));
        end
        reset = 1'b1; ini_done = 1'b0;
        tick();
        chk("midref_reset_bus", 32'(a_bus), 32'(BUS_DES));
        chk("midref_reset_ready", 32'(a_rdy), 32'd0);
        chk("midref_reset_busy", 32'(a_busy), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("midref_no_ref%0d", k), 32'(a_bus), 32'(BUS_DES));
        end

        // overrun: instance B expires again at edge 16 while in tRFC
        ini_done = 1'b1;
        tick();
        for (int m = 1; m <= 40; m++) begin
            tick();
            if (m == 2 * TB_REFI - 1) chk("ovr_before", 32'(b_ovr), 32'd0);
            if (m == 2 * TB_REFI)     chk("ovr_set", 32'(b_ovr), 32'd1);
            if (m == 40) begin
                chk("ovr_hold", 32'(b_ovr), 32'd1);
                chk("ovr_a_clear", 32'(a_ovr), 32'd0);
            end
        end
        ini_done = 1'b0;
        tick();
        chk("ovr_sticky_init", 32'(b_ovr), 32'd1);
        reset = 1'b1;
        tick();
        chk("ovr_reset_clear", 32'(b_ovr), 32'd0);
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
